// File: rtl/score_event_arbiter.sv
// score_event_arbiter: round-robin scoring-event arbiter feeding a digit-serial BCD score adder
module score_event_arbiter #(
    parameter int          PENDING_W = 4,
    parameter logic [15:0] COIN_PTS  = 16'h0010,
    parameter logic [15:0] STOMP_PTS = 16'h0050,
    parameter logic [15:0] WIN_PTS   = 16'h0200
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        clear_score,
    input  logic [2:0]  req,
    output logic [15:0] score_display,
    output logic        busy,
    output logic [2:0]  grant,
    output logic [2:0]  drop,
    output logic        score_sat
);
    typedef enum logic {IDLE, ADD} state_t;
    state_t state, state_next;
    logic [2:0][PENDING_W-1:0] pend;
    logic [2:0]  pend_nz, rot, take_vec, ptr_off;
    logic [1:0]  ptr, off, src, digit;
    logic [15:0] acc, addend, commit_val;
    logic        carry, take, commit, cout;
    logic [3:0]  dig_a, dig_b, dig_res;
    logic [4:0]  sum;
    // pending flags rotated so bit 0 is the first candidate after the last grant
    always_comb begin
        pend_nz = {|pend[2], |pend[1], |pend[0]};
        rot     = ptr == 2'd1 ? {pend_nz[0], pend_nz[2], pend_nz[1]} :
                  ptr == 2'd2 ? {pend_nz[1], pend_nz[0], pend_nz[2]} : pend_nz;
        off     = rot[0] ? 2'd0 : rot[1] ? 2'd1 : 2'd2;
        ptr_off = {1'b0, ptr} + {1'b0, off};
        src     = ptr_off >= 3'd3 ? 2'(ptr_off - 3'd3) : ptr_off[1:0];
    end
    // one BCD digit of acc + addend + carry; a carry out of digit 3 clamps the score
    always_comb begin
        dig_a      = acc[{digit, 2'b00} +: 4];
        dig_b      = addend[{digit, 2'b00} +: 4];
        sum        = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry};
        cout       = sum > 5'd9;
        dig_res    = cout ? 4'(sum - 5'd10) : sum[3:0];
        commit_val = cout ? 16'h9999 : {dig_res, acc[11:0]};
    end
    // state register; clear_score aborts an addition in progress
    always_ff @(posedge Clk) begin
        if (Reset || clear_score) state <= IDLE;
        else state <= state_next;
    end
    // next state: leave IDLE when anything is pending, return after digit 3
    always_comb begin
        state_next = state == IDLE ? (|pend_nz ? ADD : IDLE) : (digit == 2'd3 ? IDLE : ADD);
    end
    // FSM decodes: grant decision in IDLE, commit on the last digit
    always_comb begin
        take     = state == IDLE && |pend_nz;
        commit   = state == ADD && digit == 2'd3;
        take_vec = take ? 3'(3'b001 << src) : 3'b000;
    end
    // pending counters, arbitration pointer, digit-serial accumulator and score
    always_ff @(posedge Clk) begin
        if (Reset || clear_score) begin
            pend          <= '0;
            score_display <= '0;
            busy          <= 1'b0;
            grant         <= '0;
            drop          <= '0;
            score_sat     <= 1'b0;
            acc           <= '0;
            addend        <= '0;
            carry         <= 1'b0;
            digit         <= '0;
            if (Reset) ptr <= '0;
        end else begin
            grant <= take_vec;
            drop  <= '0;
            for (int s = 0; s < 3; s++) begin
                if (req[s] && !take_vec[s]) begin
                    if (&pend[s]) drop[s] <= 1'b1;
                    else pend[s] <= pend[s] + 1'b1;
                end else if (!req[s] && take_vec[s]) begin
                    pend[s] <= pend[s] - 1'b1;
                end
            end
            if (take) begin
                ptr    <= src == 2'd2 ? 2'd0 : src + 2'd1;
                addend <= src == 2'd0 ? COIN_PTS : src == 2'd1 ? STOMP_PTS : WIN_PTS;
                acc    <= score_display;
                carry  <= 1'b0;
                digit  <= '0;
                busy   <= 1'b1;
            end
            if (state == ADD) begin
                acc[{digit, 2'b00} +: 4] <= dig_res;
                carry <= cout;
                digit <= digit + 2'd1;
            end
            if (commit) begin
                score_display <= commit_val;
                busy          <= |pend_nz || |req;
                if (cout) score_sat <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_score_event_arbiter.sv
// tb_score_event_arbiter: directed self-checking bench for score_event_arbiter
module tb_score_event_arbiter;
    logic        clk, rst, clear_score;
    logic [2:0]  req;
    logic [15:0] score_display;
    logic        busy, score_sat;
    logic [2:0]  grant, drop;
    int total = 0;
    int bad = 0;

    score_event_arbiter #(.PENDING_W(2)) dut (
        .Clk(clk), .Reset(rst), .clear_score(clear_score), .req(req),
        .score_display(score_display), .busy(busy), .grant(grant),
        .drop(drop), .score_sat(score_sat)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; clear_score = 0; req = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic do_event(input int src);
        req = 3'(1 << src);
        tick();
        req = 0;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (score_display !== 16'h0000) begin bad++; $display("FAIL reset_score got=%h exp=0000", score_display); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b exp=000", grant); end
        total++; if (drop !== 3'b000) begin bad++; $display("FAIL reset_drop got=%b exp=000", drop); end
        total++; if (score_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", score_sat); end
    endtask

    task automatic test_single_coin();
        int busy_cnt;
        do_reset();
        req = 3'b001;
        tick();
        req = 0;
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL coin_grant_e0 got=%b exp=000", grant); end
        busy_cnt = 0;
        for (int t = 1; t <= 5; t++) begin
            if (t == 5) begin
                total++; if (score_display !== 16'h0000) begin bad++; $display("FAIL coin_stable got=%h exp=0000", score_display); end
            end
            tick();
            if (busy) busy_cnt++;
            if (t == 1) begin
                total++; if (grant !== 3'b001) begin bad++; $display("FAIL coin_grant_e1 got=%b exp=001", grant); end
            end
            if (t == 2) begin
                total++; if (grant !== 3'b000) begin bad++; $display("FAIL coin_grant_pulse got=%b exp=000", grant); end
            end
        end
        total++; if (score_display !== 16'h0010) begin bad++; $display("FAIL coin_score got=%h exp=0010", score_display); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL coin_busy_end got=%b exp=0", busy); end
        total++; if (busy_cnt !== 4) begin bad++; $display("FAIL coin_busy_cycles got=%0d exp=4", busy_cnt); end
    endtask

    task automatic test_carry();
        do_reset();
        repeat (9) do_event(0);
        total++; if (score_display !== 16'h0090) begin bad++; $display("FAIL carry_pre90 got=%h exp=0090", score_display); end
        do_event(0);
        total++; if (score_display !== 16'h0100) begin bad++; $display("FAIL carry_0100 got=%h exp=0100", score_display); end
        do_reset();
        repeat (4) do_event(2);
        repeat (3) do_event(1);
        total++; if (score_display !== 16'h0950) begin bad++; $display("FAIL carry_pre950 got=%h exp=0950", score_display); end
        do_event(1);
        total++; if (score_display !== 16'h1000) begin bad++; $display("FAIL carry_1000 got=%h exp=1000", score_display); end
    endtask

    task automatic test_simultaneous();
        logic [2:0]  eg;
        logic [15:0] es;
        do_reset();
        req = 3'b111;
        tick();
        req = 0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            eg = t == 1 ? 3'b001 : t == 6 ? 3'b010 : t == 11 ? 3'b100 : 3'b000;
            es = t < 5 ? 16'h0000 : t < 10 ? 16'h0010 : t < 15 ? 16'h0060 : 16'h0260;
            total++; if (grant !== eg) begin bad++; $display("FAIL simul_grant t=%0d got=%b exp=%b", t, grant, eg); end
            total++; if (score_display !== es) begin bad++; $display("FAIL simul_score t=%0d got=%h exp=%h", t, score_display, es); end
            total++; if (busy !== (t < 15)) begin bad++; $display("FAIL simul_busy t=%0d got=%b exp=%b", t, busy, t < 15); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (49) do_event(2);
        repeat (3) do_event(1);
        repeat (4) do_event(0);
        total++; if (score_display !== 16'h9990) begin bad++; $display("FAIL sat_pre got=%h exp=9990", score_display); end
        total++; if (score_sat !== 1'b0) begin bad++; $display("FAIL sat_pre_flag got=%b exp=0", score_sat); end
        do_event(1);
        total++; if (score_display !== 16'h9999) begin bad++; $display("FAIL sat_clamp got=%h exp=9999", score_display); end
        total++; if (score_sat !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b exp=1", score_sat); end
        do_event(0);
        total++; if (score_display !== 16'h9999) begin bad++; $display("FAIL sat_hold got=%h exp=9999", score_display); end
        total++; if (score_sat !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%b exp=1", score_sat); end
        clear_score = 1;
        tick();
        clear_score = 0;
        total++; if (score_display !== 16'h0000) begin bad++; $display("FAIL sat_clear_score got=%h exp=0000", score_display); end
        total++; if (score_sat !== 1'b0) begin bad++; $display("FAIL sat_clear_flag got=%b exp=0", score_sat); end
    endtask

    task automatic test_overflow();
        int grants;
        do_reset();
        grants = 0;
        req = 3'b001;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (grant[0]) grants++;
            total++; if (drop !== (i >= 4 ? 3'b001 : 3'b000)) begin bad++; $display("FAIL ovf_drop i=%0d got=%b exp=%b", i, drop, i >= 4 ? 3'b001 : 3'b000); end
        end
        req = 0;
        tick();
        if (grant[0]) grants++;
        total++; if (drop !== 3'b000) begin bad++; $display("FAIL ovf_drop_end got=%b exp=000", drop); end
        repeat (25) begin
            tick();
            if (grant[0]) grants++;
        end
        total++; if (grants !== 4) begin bad++; $display("FAIL ovf_grants got=%0d exp=4", grants); end
        total++; if (score_display !== 16'h0040) begin bad++; $display("FAIL ovf_score got=%h exp=0040", score_display); end
    endtask

    task automatic test_clear_mid();
        int grants;
        do_reset();
        do_event(0);
        req = 3'b001;
        tick();
        req = 0;
        tick();
        tick();
        clear_score = 1;
        tick();
        clear_score = 0;
        total++; if (score_display !== 16'h0000) begin bad++; $display("FAIL clr_score got=%h exp=0000", score_display); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b exp=0", busy); end
        grants = 0;
        repeat (10) begin
            tick();
            if (grant != 3'b000 || busy) grants++;
        end
        total++; if (grants !== 0) begin bad++; $display("FAIL clr_no_activity got=%0d exp=0", grants); end
        total++; if (score_display !== 16'h0000) begin bad++; $display("FAIL clr_no_commit got=%h exp=0000", score_display); end
        do_event(1);
        total++; if (score_display !== 16'h0050) begin bad++; $display("FAIL clr_after got=%h exp=0050", score_display); end
    endtask

    initial begin
        rst = 1; clear_score = 0; req = 0;
        test_reset();
        test_single_coin();
        test_carry();
        test_simultaneous();
        test_saturation();
        test_overflow();
        test_clear_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
